// File: rtl/axi_dram_resp_model.sv
// axi_dram_resp_model
//
// AXI4 responder standing in for the DRAM memory controller. Requests are
// served from an on-chip word array. One write burst and one read burst can
// be in flight at a time, and the write and read engines run independently.
// Error responses keep cycle-exact timing, so upstream cuts, clock crossings
// and ID handling can be verified against it.
//
// Ports
//   clk_i, rst_ni             clock, synchronous active-low reset
//   aw_*_i / aw_ready_o       write request channel (id, addr, len, size, burst)
//   w_*_i / w_ready_o         write data channel (data, strb, last)
//   b_*_o / b_ready_i         write response channel (id, resp)
//   ar_*_i / ar_ready_o       read request channel (id, addr, len, size, burst)
//   r_*_o / r_ready_i         read data channel (id, data, resp, last)
//
// Bad requests use a burst type other than FIXED or INCR, or a beat size that
// is not the full bus width. Every beat of a bad request gets SLVERR. A beat
// whose word index is outside the array gets DECERR. Read data is forced to
// zero on every beat whose response is not OKAY.
module axi_dram_resp_model #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 6,
  parameter int NumWords  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [2:0]             aw_size_i,
  input  logic [1:0]             aw_burst_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  input  logic [2:0]             ar_size_i,
  input  logic [1:0]             ar_burst_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int OffW      = $clog2(StrbWidth);
  localparam int MemAw     = (NumWords > 1) ? $clog2(NumWords) : 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst);
    return !(burst == 2'b00 || burst == 2'b01) || (size != 3'(OffW));
  endfunction

  function automatic logic in_range(input logic [AddrWidth-1:0] addr);
    return 64'(addr >> OffW) < 64'(NumWords);
  endfunction

  function automatic logic [MemAw-1:0] mem_idx(input logic [AddrWidth-1:0] addr);
    return addr[OffW +: MemAw];
  endfunction

  // INCR steps one bus word and wraps at the address width; FIXED holds.
  function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                     input logic [1:0] burst);
    return (burst == 2'b01) ? addr + AddrWidth'(StrbWidth) : addr;
  endfunction

  logic [DataWidth-1:0] mem [NumWords];

  // ---------------------------------------------------------------- write engine
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  w_state_e             w_state;
  logic [IdWidth-1:0]   w_id_q;
  logic [AddrWidth-1:0] w_addr_q;
  logic [7:0]           w_len_q;
  logic [7:0]           w_cnt_q;
  logic [1:0]           w_burst_q;
  logic                 w_bad_q;
  logic [1:0]           w_resp_q;
  logic                 aw_ready_q;
  logic                 w_ready_q;
  logic                 b_valid_q;
  logic [IdWidth-1:0]   b_id_q;
  logic [1:0]           b_resp_q;
  logic                 w_hs;
  logic [1:0]           w_resp_nxt;

  assign w_hs = w_valid_i && w_ready_q;

  // DECERR is sticky; SLVERR only upgrades from OKAY.
  always_comb begin
    w_resp_nxt = w_resp_q;
    if (!in_range(w_addr_q)) begin
      w_resp_nxt = RespDecerr;
    end else if ((w_last_i != (w_cnt_q == w_len_q)) && (w_resp_q != RespDecerr)) begin
      w_resp_nxt = RespSlverr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state    <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_ready_q && aw_valid_i) begin
            w_id_q     <= aw_id_i;
            w_addr_q   <= aw_addr_i;
            w_len_q    <= aw_len_i;
            w_burst_q  <= aw_burst_i;
            w_bad_q    <= req_bad(aw_size_i, aw_burst_i);
            w_cnt_q    <= 8'd0;
            w_resp_q   <= req_bad(aw_size_i, aw_burst_i) ? RespSlverr : RespOkay;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state    <= W_DATA;
          end else begin
            aw_ready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_resp_q <= w_resp_nxt;
            w_addr_q <= next_addr(w_addr_q, w_burst_q);
            w_cnt_q  <= w_cnt_q + 8'd1;
            // Only the beat count ends a burst; w_last_i merely grades it.
            if (w_cnt_q == w_len_q) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_id_q    <= w_id_q;
              b_resp_q  <= w_resp_nxt;
              w_state   <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= '0;
            aw_ready_q <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- array write port
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_hs && !w_bad_q && in_range(w_addr_q)) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (w_strb_i[b]) mem[mem_idx(w_addr_q)][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read engine
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  r_state_e             r_state;
  logic [AddrWidth-1:0] r_addr_q;
  logic [7:0]           r_len_q;
  logic [7:0]           r_cnt_q;
  logic [1:0]           r_burst_q;
  logic                 r_bad_q;
  logic                 ar_ready_q;
  logic                 r_valid_q;
  logic [IdWidth-1:0]   r_id_q;
  logic [DataWidth-1:0] r_data_q;
  logic [1:0]           r_resp_q;
  logic                 r_last_q;
  logic [AddrWidth-1:0] rd_addr;
  logic                 rd_bad;
  logic [1:0]           rd_resp;
  logic [DataWidth-1:0] rd_word;

  // The read port looks at the incoming AR address while idle and at the
  // next-beat address during a burst; the result lands in the output register.
  always_comb begin
    if (r_state == R_IDLE) begin
      rd_addr = ar_addr_i;
      rd_bad  = req_bad(ar_size_i, ar_burst_i);
    end else begin
      rd_addr = r_addr_q;
      rd_bad  = r_bad_q;
    end
  end

  assign rd_resp = rd_bad ? RespSlverr : (in_range(rd_addr) ? RespOkay : RespDecerr);
  assign rd_word = mem[mem_idx(rd_addr)];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
    end else if (r_state == R_IDLE) begin
      if (ar_ready_q && ar_valid_i) begin
        r_len_q    <= ar_len_i;
        r_burst_q  <= ar_burst_i;
        r_bad_q    <= rd_bad;
        r_cnt_q    <= 8'd0;
        r_addr_q   <= next_addr(ar_addr_i, ar_burst_i);
        r_id_q     <= ar_id_i;
        r_valid_q  <= 1'b1;
        r_resp_q   <= rd_resp;
        r_data_q   <= (rd_resp == RespOkay) ? rd_word : '0;
        r_last_q   <= (ar_len_i == 8'd0);
        ar_ready_q <= 1'b0;
        r_state    <= R_DATA;
      end else begin
        ar_ready_q <= 1'b1;
      end
    end else if (r_ready_i) begin
      if (r_last_q) begin
        r_valid_q  <= 1'b0;
        r_id_q     <= '0;
        r_data_q   <= '0;
        r_resp_q   <= '0;
        r_last_q   <= 1'b0;
        ar_ready_q <= 1'b1;
        r_state    <= R_IDLE;
      end else begin
        r_cnt_q  <= r_cnt_q + 8'd1;
        r_addr_q <= next_addr(r_addr_q, r_burst_q);
        r_resp_q <= rd_resp;
        r_data_q <= (rd_resp == RespOkay) ? rd_word : '0;
        r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
      end
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = b_id_q;
  assign b_resp_o   = b_resp_q;
  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign r_last_o   = r_last_q;

endmodule
